// File: rtl/bg_noise_accum_pkg.sv
// ---------------------------------------------------------------------------
// bg_noise_accum_pkg
// Shared definitions for the background-noise accumulator: lane geometry,
// sample/accumulator widths, period counter width, FSM state encoding and the
// per-lane mean helper.
// ---------------------------------------------------------------------------
package bg_noise_accum_pkg;

  localparam int NUM_LANES = 16;
  localparam int SAMPLE_W  = 8;
  localparam int ACC_W     = 16;
  localparam int CNT_W     = 9;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Arithmetic shift floors toward minus infinity; the low byte is the mean.
  function automatic logic [SAMPLE_W-1:0] lane_mean(
    input logic signed [ACC_W-1:0] acc,
    input int                      shift
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> shift;
    return shifted[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/bg_noise_accum_lane_add16.sv
// ---------------------------------------------------------------------------
// lane_add16
// Purely combinational 16-lane adder: each 16-bit signed accumulator lane
// plus its sign-extended 8-bit signed sample.
// Ports:
//   i_acc  [NUM_LANES*ACC_W]    current accumulator lanes
//   i_samp [NUM_LANES*SAMPLE_W] sample lanes
//   o_sum  [NUM_LANES*ACC_W]    updated accumulator lanes
// ---------------------------------------------------------------------------
module lane_add16
  import bg_noise_accum_pkg::*;
(
  input  logic [NUM_LANES*ACC_W-1:0]    i_acc,
  input  logic [NUM_LANES*SAMPLE_W-1:0] i_samp,
  output logic [NUM_LANES*ACC_W-1:0]    o_sum
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [ACC_W-1:0] w_ext;
    assign w_ext = {{(ACC_W-SAMPLE_W){i_samp[g*SAMPLE_W+SAMPLE_W-1]}},
                    i_samp[g*SAMPLE_W +: SAMPLE_W]};
    assign o_sum[g*ACC_W +: ACC_W] = i_acc[g*ACC_W +: ACC_W] + w_ext;
  end

endmodule

// File: rtl/bg_noise_accum.sv
// ---------------------------------------------------------------------------
// bg_noise_accum
// Averages 2^LOG2_PERIODS period vectors of 16 signed 8-bit noise lanes and
// presents the per-lane mean with a valid/ready handshake.
// Ports:
//   clk, rst (async, active high), clear (sync restart of the estimate)
//   PeriodData/in_valid/in_ready  : input vector stream
//   NoiseMean/out_valid/out_ready : mean result, held until taken
//   period_cnt                    : vectors accumulated into current estimate
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_ACCUM | accepting vectors into the lane accumulators
// ST_HOLD  | estimate complete, NoiseMean valid, waiting for out_ready
// ---------------------------------------------------------------------------
module bg_noise_accum
  import bg_noise_accum_pkg::*;
#(
  parameter int LOG2_PERIODS = 6,
  parameter int LANES        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [LANES*SAMPLE_W-1:0] PeriodData,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*SAMPLE_W-1:0] NoiseMean,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          period_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_PERIODS) - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [LANES*ACC_W-1:0]     r_acc;
  logic [LANES*ACC_W-1:0]     w_sum;
  logic [LANES*SAMPLE_W-1:0]  w_mean;
  logic [CNT_W-1:0]           r_cnt;
  logic                       w_xfer_in;
  logic                       w_xfer_out;

  lane_add16 u_lane_add16 (
    .i_acc  (r_acc),
    .i_samp (PeriodData),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_xfer_in   = 1'b0;
    w_xfer_out  = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        // rst gating keeps in_ready low while the async reset is held.
        in_ready  = ~clear & ~rst;
        w_xfer_in = in_valid & in_ready;
        if (w_xfer_in && (r_cnt == LAST_CNT)) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid  = 1'b1;
        w_xfer_out = out_ready & ~clear;
        if (w_xfer_out) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
    if (clear) w_state_nxt = ST_ACCUM;
  end

  // Clear and output handshake both restart the estimate; clear wins over
  // an input transfer because in_ready is already forced low by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear || w_xfer_out) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_xfer_in) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_mean
    assign w_mean[g*SAMPLE_W +: SAMPLE_W] = lane_mean(r_acc[g*ACC_W +: ACC_W], LOG2_PERIODS);
  end

  assign NoiseMean  = out_valid ? w_mean : '0;
  assign period_cnt = r_cnt;

endmodule

// File: tb/tb_bg_noise_accum.sv
// ---------------------------------------------------------------------------
// tb_bg_noise_accum
// Directed bench for bg_noise_accum with two instances: LOG2_PERIODS=2 and
// LOG2_PERIODS=8. Expected means come from a per-lane sum model and are
// queued when the final vector of an estimate is driven, then popped when
// the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_bg_noise_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;

  logic         clear2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] pd2, nm2;
  logic [8:0]   pc2;

  logic         clear8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [127:0] pd8, nm8;
  logic [8:0]   pc8;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] sb2[$];
  logic [127:0] sb8[$];
  logic [127:0] held2;
  int           sum2[16];
  int           cnt2;

  bg_noise_accum #(.LOG2_PERIODS(2), .LANES(16)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .PeriodData(pd2), .in_valid(in_valid2),
    .in_ready(in_ready2), .NoiseMean(nm2), .out_valid(out_valid2),
    .out_ready(out_ready2), .period_cnt(pc2)
  );

  bg_noise_accum #(.LOG2_PERIODS(8), .LANES(16)) dut8 (
    .clk(clk), .rst(rst), .clear(clear8), .PeriodData(pd8), .in_valid(in_valid8),
    .in_ready(in_ready8), .NoiseMean(nm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .period_cnt(pc8)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset2();
    for (int i = 0; i < 16; i++) sum2[i] = 0;
    cnt2 = 0;
  endtask

  task automatic model_add2(input logic [127:0] d);
    logic [127:0] m;
    byte          b;
    for (int i = 0; i < 16; i++) begin
      b = d[i*8 +: 8];
      sum2[i] = sum2[i] + int'(b);
    end
    cnt2++;
    if (cnt2 == 4) begin
      for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(sum2[i] >>> 2);
      sb2.push_back(m);
      model_reset2();
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the next negedge with in_valid2 low.
  task automatic push2(input string tag, input logic [127:0] d);
    pd2 = d;
    in_valid2 = 1'b1;
    #1;
    check({tag, "_in_ready"}, 128'(in_ready2), 128'(1'b1));
    @(negedge clk);
    in_valid2 = 1'b0;
    pd2 = rnd128();
    model_add2(d);
  endtask

  task automatic pop_check2(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid2), 128'(1'b1));
    check({tag, "_sb_depth"}, 128'(sb2.size()), 128'(1));
    if (sb2.size() > 0) begin
      held2 = sb2.pop_front();
      check({tag, "_mean"}, nm2, held2);
    end
    check({tag, "_period_cnt"}, 128'(pc2), 128'(4));
  endtask

  task automatic handshake2(input string tag);
    out_ready2 = 1'b1;
    #1;
    check({tag, "_in_ready_hold"}, 128'(in_ready2), 128'(1'b0));
    @(negedge clk);
    out_ready2 = 1'b0;
    check({tag, "_valid_after"}, 128'(out_valid2), 128'(1'b0));
    check({tag, "_cnt_after"}, 128'(pc2), 128'(0));
    check({tag, "_mean_zero"}, nm2, 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    int           s8;
    rst = 1'b1;
    clear2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; pd2 = '0;
    clear8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; pd8 = '0;
    model_reset2();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready2), 128'(1'b0));
    check("rst_out_valid", 128'(out_valid2), 128'(1'b0));
    check("rst_mean", nm2, 128'(0));
    check("rst_cnt", 128'(pc2), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready2), 128'(1'b1));

    // four vectors of +5, with idle cycles that must be ignored
    push2("p5_0", {16{8'd5}});
    push2("p5_1", {16{8'd5}});
    pd2 = rnd128();
    repeat (3) @(negedge clk);
    check("idle_cnt", 128'(pc2), 128'(2));
    check("idle_valid", 128'(out_valid2), 128'(1'b0));
    push2("p5_2", {16{8'd5}});
    push2("p5_3", {16{8'd5}});
    pop_check2("plus5");
    check("plus5_const", nm2, {16{8'd5}});
    handshake2("plus5_hs");

    // lane 0: -3,-3,-3,-2, other lanes random
    d = rnd128(); d[7:0] = 8'hFD; push2("neg_0", d);
    d = rnd128(); d[7:0] = 8'hFD; push2("neg_1", d);
    d = rnd128(); d[7:0] = 8'hFD; push2("neg_2", d);
    d = rnd128(); d[7:0] = 8'hFE; push2("neg_3", d);
    pop_check2("neg");
    check("neg_lane0", 128'(nm2[7:0]), 128'(8'hFD));

    // stall in HOLD with in_valid high
    for (int k = 0; k < 10; k++) begin
      in_valid2 = 1'b1;
      pd2 = rnd128();
      #1;
      check("stall_in_ready", 128'(in_ready2), 128'(1'b0));
      @(negedge clk);
      check("stall_mean", nm2, held2);
      check("stall_cnt", 128'(pc2), 128'(4));
    end
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    in_valid2 = 1'b0;
    check("stall_hs_valid", 128'(out_valid2), 128'(1'b0));
    check("stall_hs_cnt", 128'(pc2), 128'(0));
    @(negedge clk);
    check("stall_hs_valid2", 128'(out_valid2), 128'(1'b0));
    check("stall_hs_cnt2", 128'(pc2), 128'(0));

    // clear with a simultaneous input vector after 3 of 4
    push2("clr_0", rnd128());
    push2("clr_1", rnd128());
    push2("clr_2", rnd128());
    check("clr_pre_cnt", 128'(pc2), 128'(3));
    clear2 = 1'b1;
    in_valid2 = 1'b1;
    pd2 = rnd128();
    #1;
    check("clr_in_ready", 128'(in_ready2), 128'(1'b0));
    @(negedge clk);
    clear2 = 1'b0;
    in_valid2 = 1'b0;
    check("clr_cnt", 128'(pc2), 128'(0));
    check("clr_valid", 128'(out_valid2), 128'(1'b0));
    model_reset2();
    for (int k = 0; k < 4; k++) push2("post_clr", rnd128());
    pop_check2("post_clr");
    handshake2("post_clr_hs");

    // async reset in HOLD
    for (int k = 0; k < 4; k++) push2("rst_fill", rnd128());
    check("rst_fill_valid", 128'(out_valid2), 128'(1'b1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid2), 128'(1'b0));
    check("arst_mean", nm2, 128'(0));
    check("arst_cnt", 128'(pc2), 128'(0));
    check("arst_in_ready", 128'(in_ready2), 128'(1'b0));
    #3 rst = 1'b0;
    sb2.delete();
    model_reset2();
    @(negedge clk);
    check("arst_rel_valid", 128'(out_valid2), 128'(1'b0));
    for (int k = 0; k < 4; k++) push2("post_rst", rnd128());
    pop_check2("post_rst");
    handshake2("post_rst_hs");

    // LOG2_PERIODS=8: 256 vectors of -128
    s8 = 0;
    in_valid8 = 1'b1;
    pd8 = {16{8'h80}};
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      s8 = s8 - 128;
    end
    in_valid8 = 1'b0;
    sb8.push_back({16{8'(s8 >>> 8)}});
    check("min_valid", 128'(out_valid8), 128'(1'b1));
    check("min_cnt", 128'(pc8), 128'(256));
    check("min_sb_depth", 128'(sb8.size()), 128'(1));
    if (sb8.size() > 0) check("min_mean", nm8, sb8.pop_front());
    check("min_const", nm8, {16{8'h80}});
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("min_hs_valid", 128'(out_valid8), 128'(1'b0));
    check("min_hs_cnt", 128'(pc8), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bg_noise_accum.md
BG_NOISE_ACCUM -- requirements
Module: bg_noise_accum

Interface
REQ-001 SHALL have parameter LOG2_PERIODS, default 6, meaning log2 of the number of period vectors averaged per estimate (legal range 1..8).
REQ-002 SHALL have parameter LANES, default 16, meaning number of parallel noise lanes (fixed at 16 in this revision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous restart of the current estimate.
REQ-006 SHALL have port PeriodData  input  128  16 signed 8-bit lane samples, lane i at bits [8i+7:8i].
REQ-007 SHALL have port in_valid  input  1  PeriodData valid.
REQ-008 SHALL have port in_ready  output  1  block accepts PeriodData this cycle.
REQ-009 SHALL have port NoiseMean  output  128  16 signed 8-bit lane means, same lane packing as PeriodData.
REQ-010 SHALL have port out_valid  output  1  NoiseMean valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes NoiseMean.
REQ-012 SHALL have port period_cnt  output  9  number of vectors accumulated into the current estimate.

Function
REQ-013 SHALL implement states ACCUM and HOLD; reset state is ACCUM.
REQ-014 SHALL drive in_ready = 1 in ACCUM when clear = 0, and 0 in HOLD or when clear = 1.
REQ-015 SHALL, on an input transfer (in_valid & in_ready), set each 16-bit signed lane accumulator to its old value plus the sign-extended 8-bit sample, and increment period_cnt by 1.
REQ-016 SHALL never overflow a lane: 256 x 8-bit signed samples fit in 16 bits signed; no saturation logic is required.
REQ-017 SHALL, on the transfer that makes period_cnt equal 2^LOG2_PERIODS, move to HOLD on the same edge; out_valid SHALL be 1 in the following cycle (latency 1 cycle from final accepted vector).
REQ-018 SHALL drive NoiseMean lane i = accumulator lane i arithmetically shifted right by LOG2_PERIODS (floor toward minus infinity), truncated to 8 bits.
REQ-019 SHALL hold NoiseMean, out_valid and the accumulators stable in HOLD until out_valid & out_ready.
REQ-020 SHALL, on out_valid & out_ready, zero all accumulators and period_cnt and return to ACCUM on that edge; out_valid SHALL be 0 the next cycle.
REQ-021 SHALL, on clear = 1 in any state, zero accumulators and period_cnt, drop any held result (out_valid -> 0) and enter ACCUM; clear has priority over input transfer and output handshake in the same cycle.
REQ-022 SHALL drive out_valid = 1 only in HOLD and NoiseMean = 0 whenever out_valid = 0.
REQ-023 SHALL not accept input in the cycle of an output handshake (in_ready = 0 in HOLD); the first vector of the next estimate is accepted one cycle later at the earliest.
REQ-024 SHALL ignore PeriodData when in_valid = 0 (no accumulation, no count change).

Reset
REQ-025 SHALL, while rst = 1, force state ACCUM, all accumulators 0, period_cnt 0, out_valid 0, NoiseMean 0, in_ready 0.
REQ-026 SHALL, on rst asserted mid-estimate or in HOLD, discard all partial sums and any held result without producing an output transfer.

Structure
REQ-027 SHALL place the lane count, sample width (8), accumulator width (16) and state encoding in the shared detection package.
REQ-028 SHALL contain one sub-module, lane_add16, the purely combinational 16-lane signed 8+16-bit adder; state, counter and handshake logic reside in bg_noise_accum.

Verification
REQ-029 SHALL cover: LOG2_PERIODS=2, four vectors all lanes = +5 -> out_valid one cycle after 4th transfer, every NoiseMean lane = 5, period_cnt = 4.
REQ-030 SHALL cover: LOG2_PERIODS=2, lane 0 samples -3,-3,-3,-2 -> lane 0 sum -11, NoiseMean lane 0 = -3 (0xFD).
REQ-031 SHALL cover: LOG2_PERIODS=8, 256 vectors all lanes = -128 -> accumulator -32768 without wrap, NoiseMean lanes = -128 (0x80).
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in HOLD with in_valid = 1 -> in_ready stays 0, NoiseMean unchanged, no accumulation; out_ready = 1 -> one transfer, period_cnt 0 next cycle.
REQ-033 SHALL cover: clear = 1 together with in_valid = 1 after 3 of 4 vectors -> sample dropped, period_cnt 0, next full estimate uses only post-clear vectors.
REQ-034 SHALL cover: rst pulsed asynchronously (mid-cycle) during HOLD -> out_valid falls immediately, all outputs 0, normal accumulation resumes after release.
